// File: rtl/hermes_local_injector.sv
// Local-port packetizer for a Hermes router: turns a (target, length) command plus a
// payload word stream into a header flit and payload flits, paced by the router credit.
module hermes_local_injector #(
  parameter int FLIT_SIZE = 32,
  parameter int LEN_W     = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [15:0]          cmd_target_i,
  input  logic [LEN_W-1:0]     cmd_len_i,
  input  logic                 pld_valid_i,
  output logic                 pld_ready_o,
  input  logic [FLIT_SIZE-1:0] pld_data_i,
  output logic                 tx_o,
  output logic                 eop_o,
  output logic [FLIT_SIZE-1:0] data_o,
  input  logic                 credit_i,
  output logic                 busy_o,
  output logic                 pkt_sent_o
);

  typedef enum logic [1:0] {IDLE, HDR, PLD} state_t;

  state_t               state_q, state_d;
  logic [15:0]          target_q, target_d;
  logic [LEN_W-1:0]     remaining_q, remaining_d;
  logic                 tx_q, eop_q, pkt_sent_q;
  logic [FLIT_SIZE-1:0] data_q;

  logic                 reg_free;
  logic                 cmd_accept;
  logic                 load;
  logic                 load_eop;
  logic [FLIT_SIZE-1:0] load_data;

  function automatic logic [FLIT_SIZE-1:0] header_flit(input logic [15:0] target);
    logic [FLIT_SIZE-1:0] flit;
    flit       = '0;
    flit[15:0] = target;
    return flit;
  endfunction

  // The output register may take a new flit when it is empty or its flit leaves this cycle.
  assign reg_free = !tx_q || credit_i;

  // NOTE: every always_comb output gets a default before the case, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    remaining_d = remaining_q;
    load        = 1'b0;
    load_eop    = 1'b0;
    load_data   = data_q;
    cmd_ready_o = 1'b0;
    cmd_accept  = 1'b0;
    pld_ready_o = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready_o = !rst_i;
        cmd_accept  = cmd_valid_i && !rst_i;
        if (cmd_accept) begin
          target_d    = cmd_target_i;
          remaining_d = cmd_len_i;
          if (reg_free) begin
            load      = 1'b1;
            load_data = header_flit(cmd_target_i);
            load_eop  = (cmd_len_i == '0);
            state_d   = (cmd_len_i == '0) ? IDLE : PLD;
          end else begin
            state_d = HDR;
          end
        end
      end
      HDR: begin
        if (reg_free) begin
          load      = 1'b1;
          load_data = header_flit(target_q);
          load_eop  = (remaining_q == '0);
          state_d   = (remaining_q == '0) ? IDLE : PLD;
        end
      end
      PLD: begin
        pld_ready_o = reg_free;
        if (pld_valid_i && reg_free) begin
          load        = 1'b1;
          load_data   = pld_data_i;
          load_eop    = (remaining_q == LEN_W'(1));
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      target_q    <= '0;
      remaining_q <= '0;
      tx_q        <= 1'b0;
      eop_q       <= 1'b0;
      data_q      <= '0;
      pkt_sent_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      remaining_q <= remaining_d;
      pkt_sent_q  <= tx_q && credit_i && eop_q;
      if (load) begin
        tx_q   <= 1'b1;
        eop_q  <= load_eop;
        data_q <= load_data;
      end else if (reg_free) begin
        // Flit left (or register idle) and nothing new: drop valid, data may stay.
        tx_q  <= 1'b0;
        eop_q <= 1'b0;
      end
    end
  end

  assign tx_o       = tx_q;
  assign eop_o      = eop_q;
  assign data_o     = data_q;
  assign pkt_sent_o = pkt_sent_q;
  assign busy_o     = (state_q != IDLE) || tx_q;

endmodule

// File: tb/tb_hermes_local_injector.sv
// Directed bench for hermes_local_injector: queued commands, a flit recorder acting as
// the router, and hand-built expected flit lists compared flit by flit.
module tb_hermes_local_injector;
  localparam int FLIT_SIZE = 32;
  localparam int LEN_W     = 8;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 cmd_valid_i;
  logic                 cmd_ready_o;
  logic [15:0]          cmd_target_i;
  logic [LEN_W-1:0]     cmd_len_i;
  logic                 pld_valid_i;
  logic                 pld_ready_o;
  logic [FLIT_SIZE-1:0] pld_data_i;
  logic                 tx_o;
  logic                 eop_o;
  logic [FLIT_SIZE-1:0] data_o;
  logic                 credit_i;
  logic                 busy_o;
  logic                 pkt_sent_o;

  hermes_local_injector #(.FLIT_SIZE(FLIT_SIZE), .LEN_W(LEN_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_target_i(cmd_target_i), .cmd_len_i(cmd_len_i),
    .pld_valid_i(pld_valid_i), .pld_ready_o(pld_ready_o), .pld_data_i(pld_data_i),
    .tx_o(tx_o), .eop_o(eop_o), .data_o(data_o), .credit_i(credit_i),
    .busy_o(busy_o), .pkt_sent_o(pkt_sent_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [15:0]      target;
    logic [LEN_W-1:0] len;
  } cmd_t;

  cmd_t        cmd_q[$];
  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];
  int          got_cyc[$];

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          cmd_cyc = 0;
  int          sent_cnt, eop_cnt, hold_cnt, stall_mode, stall_left, pld_idx;
  bit          rnd_gaps;
  logic [31:0] stall_val, pld_base, exp_pld_next;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_next_cmd();
    cmd_t c;
    if (cmd_q.size() > 0) begin
      c            = cmd_q.pop_front();
      cmd_valid_i  = 1'b1;
      cmd_target_i = c.target;
      cmd_len_i    = c.len;
    end else begin
      cmd_valid_i = 1'b0;
    end
  endtask

  task automatic start_test(input logic [31:0] base);
    got_q.delete(); got_cyc.delete(); exp_q.delete(); cmd_q.delete();
    pld_base = base; pld_idx = 0; pld_data_i = base; exp_pld_next = base;
    sent_cnt = 0; eop_cnt = 0; hold_cnt = 0;
    stall_mode = 0; stall_left = 0; rnd_gaps = 0;
    pld_valid_i = 1'b1; credit_i = 1'b1; cmd_valid_i = 1'b0;
  endtask

  // Queue a command and append its expected flits (header, then sequential payload words).
  task automatic push_cmd(input logic [15:0] target, input int len);
    cmd_t c;
    c.target = target;
    c.len    = LEN_W'(len);
    exp_q.push_back({(len == 0), 16'h0000, target});
    for (int k = 0; k < len; k++) begin
      exp_q.push_back({(k == len - 1), exp_pld_next});
      exp_pld_next = exp_pld_next + 32'd1;
    end
    cmd_q.push_back(c);
    if (!cmd_valid_i) load_next_cmd();
  endtask

  // One clock cycle: choose credit/valid, record transfers at negedge, advance streams.
  task automatic step();
    bit consumed, taken;
    credit_i = 1'b1;
    if (stall_left > 0 && tx_o &&
        ((stall_mode == 1 && data_o == stall_val) ||
         (stall_mode == 2 && eop_o && eop_cnt == 0))) begin
      credit_i = 1'b0;
      stall_left--;
    end
    if (rnd_gaps) pld_valid_i = ($urandom_range(0, 3) != 0);
    #1;
    if (!credit_i) check("stall_pld_ready", pld_ready_o, 0);
    if (stall_mode == 1 && tx_o && data_o == stall_val) hold_cnt++;
    @(negedge clk_i);
    if (tx_o && credit_i) begin
      got_q.push_back({eop_o, data_o});
      got_cyc.push_back(cyc);
      if (eop_o) eop_cnt++;
    end
    if (pkt_sent_o) sent_cnt++;
    consumed = pld_valid_i && pld_ready_o;
    taken    = cmd_valid_i && cmd_ready_o;
    if (taken) cmd_cyc = cyc;
    @(posedge clk_i);
    #1;
    cyc++;
    if (consumed) begin
      pld_idx++;
      pld_data_i = pld_base + 32'(pld_idx);
    end
    if (taken) load_next_cmd();
  endtask

  task automatic drain();
    int n = 0;
    while (n < 3000 && !(cmd_q.size() == 0 && !cmd_valid_i && !busy_o &&
                         got_q.size() >= exp_q.size())) begin
      step();
      n++;
    end
    if (n >= 3000) check("drain_timeout", 1, 0);
    step();
  endtask

  task automatic compare(input string name);
    check({name, "_flit_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_flit%0d", name, i), got_q[i], exp_q[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int saved;
    // 1: reset held with a command offered
    rst_i = 1'b1; cmd_valid_i = 1'b1; cmd_target_i = 16'h0102; cmd_len_i = 8'd1;
    pld_valid_i = 1'b1; pld_data_i = 32'h5; credit_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      check("rst_tx", tx_o, 0);
      check("rst_eop", eop_o, 0);
      check("rst_data", data_o, 0);
      check("rst_cmd_ready", cmd_ready_o, 0);
      check("rst_pkt_sent", pkt_sent_o, 0);
    end
    rst_i = 1'b0;
    start_test(32'h0);
    #1;
    check("idle_cmd_ready", cmd_ready_o, 1);
    step(); step();
    check("rst_no_flits", got_q.size(), 0);
    check("rst_not_busy", busy_o, 0);

    // 2: basic three-payload packet, continuous credit
    start_test(32'hA);
    push_cmd(16'h0102, 3);
    drain();
    compare("t2");
    if (got_cyc.size() >= 4) begin
      check("t2_hdr_latency", got_cyc[0] - cmd_cyc, 1);
      check("t2_back_to_back", got_cyc[3] - got_cyc[0], 3);
    end
    check("t2_pkt_sent", sent_cnt, 1);

    // 3: credit withheld 4 cycles while 0xB is presented
    start_test(32'hA);
    stall_mode = 1; stall_val = 32'hB; stall_left = 4;
    push_cmd(16'h0102, 3);
    drain();
    compare("t3");
    check("t3_hold_cycles", hold_cnt, 5);
    check("t3_pkt_sent", sent_cnt, 1);

    // 4: header-only packet
    start_test(32'h0);
    push_cmd(16'h0300, 0);
    n = 0;
    while (cmd_valid_i && n < 20) begin step(); n++; end
    check("t4_tx", tx_o, 1);
    check("t4_eop", eop_o, 1);
    check("t4_data", data_o, 32'h0000_0300);
    check("t4_cmd_ready", cmd_ready_o, 1);
    drain();
    compare("t4");
    check("t4_pkt_sent", sent_cnt, 1);

    // 5: back-to-back commands, first eop flit stalled 3 cycles
    start_test(32'h100);
    stall_mode = 2; stall_left = 3;
    push_cmd(16'h0201, 2);
    push_cmd(16'h0405, 1);
    drain();
    compare("t5");
    if (got_cyc.size() >= 4) begin
      check("t5_eop_stall", got_cyc[2] - got_cyc[1], 4);
      check("t5_hdr_after_eop", got_cyc[3] - got_cyc[2], 1);
    end
    check("t5_eop_count", eop_cnt, 2);
    check("t5_pkt_sent", sent_cnt, 2);

    // 6a: maximum length with random payload gaps
    start_test(32'h1000);
    rnd_gaps = 1;
    push_cmd(16'h0A0B, 255);
    drain();
    compare("t6");
    check("t6_eop_count", eop_cnt, 1);
    check("t6_pkt_sent", sent_cnt, 1);

    // 6b: reset in the middle of a long packet
    start_test(32'h2000);
    push_cmd(16'h0C0D, 255);
    n = 0;
    while (got_q.size() < 20 && n < 200) begin step(); n++; end
    rst_i = 1'b1;
    cmd_q.delete();
    cmd_valid_i = 1'b0;
    @(posedge clk_i); #1;
    check("t6_rst_tx", tx_o, 0);
    check("t6_rst_eop", eop_o, 0);
    check("t6_rst_busy", busy_o, 0);
    check("t6_rst_cmd_ready", cmd_ready_o, 0);
    rst_i = 1'b0;
    #1;
    check("t6_idle_cmd_ready", cmd_ready_o, 1);
    check("t6_no_eop", eop_cnt, 0);
    saved = got_q.size();
    step(); step(); step();
    check("t6_no_more_flits", got_q.size(), saved);
    check("t6_still_idle", busy_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hermes_local_injector.md
Name: hermes_local_injector

Overview:
- Packetizer on the local port of one Hermes router, upstream of the router's local input.
- Takes a command (target address, payload length) plus a payload word stream and emits a Hermes packet.
- The packet is a header flit, then the payload flits, with eop marking the last flit.
- Drives rx/eop/data of the router local input and obeys its credit signal; one instance per router tile.

Parameters:
FLIT_SIZE, 32, flit width in bits; minimum 20.
LEN_W, 8, width of the payload length field; max payload = 2^LEN_W-1 flits.

Ports:
clk_i  input  1  clock.
rst_i  input  1  synchronous reset, active-high.
cmd_valid_i  input  1  packet command valid.
cmd_ready_o  output  1  command accepted when cmd_valid_i && cmd_ready_o.
cmd_target_i  input  16  target router address, (x<<8)|y.
cmd_len_i  input  LEN_W  payload flit count; 0 means header-only packet.
pld_valid_i  input  1  payload word valid.
pld_ready_o  output  1  payload word consumed when pld_valid_i && pld_ready_o.
pld_data_i  input  FLIT_SIZE  payload word.
tx_o  output  1  flit valid toward router rx.
eop_o  output  1  current flit is last of packet.
data_o  output  FLIT_SIZE  flit toward router data.
credit_i  input  1  router can accept a flit this cycle.
busy_o  output  1  state != IDLE or tx_o high.
pkt_sent_o  output  1  one-cycle pulse when an eop flit transfers.

Behaviour:
- Reset: tx_o=0, eop_o=0, data_o=0, pkt_sent_o=0, cmd_ready_o=0 during reset; state=IDLE; counters=0.
- Flit transfer: occurs on a cycle with tx_o && credit_i.
- Output register (tx_o/eop_o/data_o):
  - The register is free when !tx_o || credit_i.
  - While tx_o && !credit_i, data_o, eop_o and tx_o hold stable.
  - When free with no new flit, tx_o clears next cycle.
- Header flit format: data[15:0]=target, data[FLIT_SIZE-1:16]=0.
- FSM states IDLE, HDR, PLD.
- IDLE:
  - cmd_ready_o=1.
  - On command accept, latch target, and latch remaining=cmd_len_i.
  - If the register is free, load the header the same edge: tx_o=1 next cycle, eop_o=(cmd_len_i==0). Next state is PLD, or IDLE if len==0.
  - If the register is not free, go to HDR.
- HDR:
  - cmd_ready_o=0.
  - Load the header when the register is free, then go to PLD, or IDLE if len==0.
- PLD:
  - cmd_ready_o=0.
  - pld_ready_o = free; this path is combinational from credit_i and tx_o.
  - On payload accept, load data_o=pld_data_i and decrement remaining.
  - eop_o=(remaining==1). When remaining reaches 0, go to IDLE.
  - pld_valid_i low: tx_o drops (bubble), no eop, state held.
- pld_ready_o=0 outside PLD; payload words offered early are not consumed.
- Latency:
  - Command accepted at cycle T with a free register: header tx_o at T+1.
  - First payload can load on the header's transfer cycle, so payload tx_o at T+2 with continuous credit.
- Back-to-back packets:
  - After the last payload loads, the FSM is IDLE.
  - The next command is accepted the following cycle.
  - Its header loads only when the register is free. If the eop flit is stalled, the header waits in HDR, so headers never overwrite a pending flit.
- pkt_sent_o is registered: high the cycle after the eop transfer.
- Max length 2^LEN_W-1: the counter must not wrap; all LEN_W bits are honoured.
- Reset mid-packet: everything clears immediately and the packet is truncated (no eop emitted). The router must be reset together with this block; this is a system requirement, not handled here.
- No combinational path from cmd_* to tx_o/data_o/eop_o; only pld_ready_o and cmd-accept decisions depend combinationally on credit_i.

Test Plan:
1. Reset held 3 cycles with cmd_valid_i=1 -> tx_o=0, eop_o=0, data_o=0, cmd_ready_o=0; no command accepted.
2. Command target=0x0102, len=3, payload 0xA,0xB,0xC always valid, credit_i=1 -> flits 0x00000102, 0xA, 0xB, 0xC on consecutive cycles; eop only on 0xC; pkt_sent_o one pulse.
3. Same packet, credit_i low for 4 cycles while 0xB is on data_o -> data_o=0xB and tx_o=1 held 4 cycles; pld_ready_o=0 throughout; no flit lost or duplicated.
4. len=0, target=0x0300 -> single flit 0x00000300 with tx_o=1, eop_o=1; FSM back to IDLE; cmd_ready_o=1 next cycle.
5. Two back-to-back commands with credit_i=0 during the first eop flit -> second header waits in HDR until the eop transfers, then appears the next cycle; eop counts equal 2.
6. len=255 with random pld_valid_i gaps -> exactly 256 flits, eop on the 256th only; rst_i asserted mid-packet -> tx_o=0 next cycle, FSM IDLE.
